// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default timing and small functions that derive
// line/frame totals and sync window bounds from the porch/pulse widths.
package vga_timing_pkg;

  // 640x480@60 with a 25 MHz pixel rate derived from a 50 MHz system clock
  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_H_DISP  = 640;
  localparam int unsigned DEF_H_FP    = 16;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_V_DISP  = 480;
  localparam int unsigned DEF_V_FP    = 10;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_CNT_W   = 10;
  localparam int unsigned DEF_FCNT_W  = 8;

  // Total positions per line (or lines per frame), blanking included
  function automatic int unsigned span_total(input int unsigned disp, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

  // First position inside the sync pulse
  function automatic int unsigned sync_first(input int unsigned disp, input int unsigned fp);
    return disp + fp;
  endfunction

  // Last position inside the sync pulse
  function automatic int unsigned sync_last(input int unsigned disp, input int unsigned fp,
                                            input int unsigned sync);
    return disp + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// Pixel clock-enable divider.
// Ports: clk, rst_n (sync, active-low), en (run enable) -> p_tick, a one-clk
// enable asserted every CLK_DIV enabled clocks. The count holds while en=0.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running modulo-CLK_DIV count, frozen while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Combinational so that CLK_DIV=1 yields p_tick=en; held low during reset
  assign p_tick = rst_n & en & (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (clk domain only).
// Ports: clk, rst_n (sync, active-low), en (run enable);
//   p_tick (pixel enable), x/y (position), hsync/vsync (polarity per
//   H_POL/V_POL), video_on, line_start/frame_start (one-clk markers),
//   frame_cnt (completed frames).
// Optional: define VGA_TIMING_LOOKAHEAD_EN to add nx/ny/nvideo_on, the
//   position and display-enable that x/y/video_on take at the next p_tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned H_DISP  = DEF_H_DISP,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_DISP  = DEF_V_DISP,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned FCNT_W  = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              p_tick,
  output logic [CNT_W-1:0]  x,
  output logic [CNT_W-1:0]  y,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic              line_start,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CNT_W-1:0]  nx,
  output logic [CNT_W-1:0]  ny,
  output logic              nvideo_on
`endif
);

  localparam int unsigned H_TOTAL = span_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_DISP, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS  = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] Y_VIS  = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(sync_first(H_DISP, H_FP));
  localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(sync_last(H_DISP, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(sync_first(V_DISP, V_FP));
  localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(sync_last(V_DISP, V_FP, V_SYNC));
  localparam logic             HS_ACT = (H_POL != 0);
  localparam logic             VS_ACT = (V_POL != 0);

  // Reject configurations the counters cannot represent
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (64'(H_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 2**CNT_W");
  end
  if (64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 2**CNT_W");
  end

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] last);
    return (v == last) ? '0 : v + CNT_W'(1);
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .p_tick (p_tick)
  );

  logic             x_wrap;
  logic             y_wrap;
  logic [CNT_W-1:0] next_x;
  logic [CNT_W-1:0] next_y;

  // Position the raster moves to on the next pixel tick
  always_comb begin
    x_wrap = (x == X_LAST);
    y_wrap = (y == Y_LAST);
    next_x = wrap_inc(x, X_LAST);
    next_y = x_wrap ? wrap_inc(y, Y_LAST) : y;
  end

  // Counters plus decode from next_x/next_y so syncs move with the coordinates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= X_LAST;
      y           <= Y_LAST;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (p_tick) begin
        x           <= next_x;
        y           <= next_y;
        hsync       <= in_window(next_x, HS_LO, HS_HI) ? HS_ACT : ~HS_ACT;
        vsync       <= in_window(next_y, VS_LO, VS_HI) ? VS_ACT : ~VS_ACT;
        video_on    <= (next_x < X_VIS) && (next_y < Y_VIS);
        line_start  <= x_wrap;
        frame_start <= x_wrap && y_wrap;
        if (x_wrap && y_wrap) begin
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
      end
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [CNT_W-1:0] nn_x;
  logic [CNT_W-1:0] nn_y;

  // One pixel beyond the lookahead position, same wrap rules as x/y
  always_comb begin
    nn_x = wrap_inc(nx, X_LAST);
    nn_y = (nx == X_LAST) ? wrap_inc(ny, Y_LAST) : ny;
  end

  // Reset values correspond to the pixel after (X_LAST, Y_LAST)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nx        <= '0;
      ny        <= '0;
      nvideo_on <= 1'b1;
    end else if (p_tick) begin
      nx        <= nn_x;
      ny        <= nn_y;
      nvideo_on <= (nn_x < X_VIS) && (nn_y < Y_VIS);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small CLK_DIV=1 instance checked against a raster model
// over two frames, and a default 640x480 instance checked at hand-computed
// points (first tick, video/hsync edges, line wrap, en freeze, mid-line reset).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-configuration instance
  logic       d_rst_n, d_en, d_p_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic [7:0] d_frame_cnt;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [9:0] d_nx, d_ny;
  logic       d_nvideo_on;
`endif

  vga_timing_gen u_def (
    .clk         (clk),
    .rst_n       (d_rst_n),
    .en          (d_en),
    .p_tick      (d_p_tick),
    .x           (d_x),
    .y           (d_y),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .video_on    (d_video_on),
    .line_start  (d_line_start),
    .frame_start (d_frame_start),
    .frame_cnt   (d_frame_cnt)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    .nx          (d_nx),
    .ny          (d_ny),
    .nvideo_on   (d_nvideo_on)
`endif
  );

  // Small instance: 8-pixel lines, 6-line frames, positive syncs
  logic       s_rst_n, s_en, s_p_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;
  logic [7:0] s_frame_cnt;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [9:0] s_nx, s_ny;
  logic       s_nvideo_on;
`endif

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1)
  ) u_sml (
    .clk         (clk),
    .rst_n       (s_rst_n),
    .en          (s_en),
    .p_tick      (s_p_tick),
    .x           (s_x),
    .y           (s_y),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start),
    .frame_cnt   (s_frame_cnt)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    .nx          (s_nx),
    .ny          (s_ny),
    .nvideo_on   (s_nvideo_on)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and sample 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int ex, ey, nk, last_fs, fs_gap;

  initial begin
    d_rst_n = 1'b0; d_en = 1'b1;
    s_rst_n = 1'b0; s_en = 1'b1;
    step(2);

    // Reset state on both instances
    chk("d_rst_x", 32'(d_x), 799);
    chk("d_rst_y", 32'(d_y), 524);
    chk("d_rst_hsync", 32'(d_hsync), 1);
    chk("d_rst_vsync", 32'(d_vsync), 1);
    chk("d_rst_video", 32'(d_video_on), 0);
    chk("d_rst_ls", 32'(d_line_start), 0);
    chk("d_rst_fs", 32'(d_frame_start), 0);
    chk("d_rst_fcnt", 32'(d_frame_cnt), 0);
    chk("d_rst_ptick", 32'(d_p_tick), 0);
    chk("s_rst_x", 32'(s_x), 7);
    chk("s_rst_y", 32'(s_y), 5);
    chk("s_rst_hsync", 32'(s_hsync), 0);
    chk("s_rst_vsync", 32'(s_vsync), 0);
    chk("s_rst_ptick", 32'(s_p_tick), 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    chk("s_rst_nx", 32'(s_nx), 0);
    chk("s_rst_ny", 32'(s_ny), 0);
    chk("s_rst_nvideo", 32'(s_nvideo_on), 1);
`endif

    // Small instance: CLK_DIV=1 ticks every clock, walk two frames plus a bit
    s_rst_n = 1'b1;
    #1;
    chk("s_ptick_en", 32'(s_p_tick), 1);
    last_fs = -1;
    fs_gap  = 0;
    for (int k = 0; k < 101; k++) begin
      step(1);
      ex = k % 8;
      ey = (k / 8) % 6;
      chk("s_x", 32'(s_x), 32'(ex));
      chk("s_y", 32'(s_y), 32'(ey));
      chk("s_hsync", 32'(s_hsync), 32'(ex == 5 || ex == 6));
      chk("s_vsync", 32'(s_vsync), 32'(ey == 4));
      chk("s_video", 32'(s_video_on), 32'(ex < 4 && ey < 3));
      chk("s_ls", 32'(s_line_start), 32'(ex == 0));
      chk("s_fs", 32'(s_frame_start), 32'(ex == 0 && ey == 0));
      chk("s_fcnt", 32'(s_frame_cnt), 32'(k / 48 + 1));
`ifdef VGA_TIMING_LOOKAHEAD_EN
      nk = k + 1;
      chk("s_nx", 32'(s_nx), 32'(nk % 8));
      chk("s_ny", 32'(s_ny), 32'((nk / 8) % 6));
      chk("s_nvideo", 32'(s_nvideo_on), 32'((nk % 8) < 4 && ((nk / 8) % 6) < 3));
`endif
      if (s_frame_start === 1'b1) begin
        if (last_fs >= 0) fs_gap = k - last_fs;
        last_fs = k;
      end
    end
    chk("s_frame_period", 32'(fs_gap), 48);

    // Default instance: first tick after release lands on (0,0)
    d_rst_n = 1'b1;
    step(1);
    chk("d_tick1_ptick", 32'(d_p_tick), 1);
    chk("d_tick1_x", 32'(d_x), 799);
    step(1);
    chk("d_first_x", 32'(d_x), 0);
    chk("d_first_y", 32'(d_y), 0);
    chk("d_first_fs", 32'(d_frame_start), 1);
    chk("d_first_ls", 32'(d_line_start), 1);
    chk("d_first_fcnt", 32'(d_frame_cnt), 1);
    chk("d_first_video", 32'(d_video_on), 1);
    chk("d_first_hsync", 32'(d_hsync), 1);
    chk("d_first_ptick", 32'(d_p_tick), 0);
    step(1);
    chk("d_fs_clear", 32'(d_frame_start), 0);
    chk("d_ls_clear", 32'(d_line_start), 0);
    chk("d_half_x", 32'(d_x), 0);
    chk("d_half_ptick", 32'(d_p_tick), 1);

    // Visible-region edge and hsync window on line 0
    step(1277);
    chk("d_x639", 32'(d_x), 639);
    chk("d_video639", 32'(d_video_on), 1);
    step(2);
    chk("d_x640", 32'(d_x), 640);
    chk("d_video640", 32'(d_video_on), 0);
    step(30);
    chk("d_x655", 32'(d_x), 655);
    chk("d_hsync655", 32'(d_hsync), 1);
    step(1);
    chk("d_hsync655b", 32'(d_hsync), 1);
    step(1);
    chk("d_x656", 32'(d_x), 656);
    chk("d_hsync656", 32'(d_hsync), 0);
    step(190);
    chk("d_x751", 32'(d_x), 751);
    chk("d_hsync751", 32'(d_hsync), 0);
    step(2);
    chk("d_x752", 32'(d_x), 752);
    chk("d_hsync752", 32'(d_hsync), 1);
    step(94);
    chk("d_x799", 32'(d_x), 799);
    chk("d_y0", 32'(d_y), 0);
    step(2);
    chk("d_wrap_x", 32'(d_x), 0);
    chk("d_wrap_y", 32'(d_y), 1);
    chk("d_wrap_ls", 32'(d_line_start), 1);
    chk("d_wrap_fs", 32'(d_frame_start), 0);
    chk("d_wrap_video", 32'(d_video_on), 1);
    chk("d_wrap_vsync", 32'(d_vsync), 1);

    // Freeze at x=100 with the divider one clock from ticking
    step(201);
    chk("d_pre_freeze_x", 32'(d_x), 100);
    chk("d_pre_freeze_ptick", 32'(d_p_tick), 1);
    d_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("d_frz_x", 32'(d_x), 100);
      chk("d_frz_y", 32'(d_y), 1);
      chk("d_frz_ptick", 32'(d_p_tick), 0);
      chk("d_frz_hsync", 32'(d_hsync), 1);
      chk("d_frz_ls", 32'(d_line_start), 0);
    end
    d_en = 1'b1;
    #1;
    chk("d_resume_ptick", 32'(d_p_tick), 1);
    step(1);
    chk("d_resume_x", 32'(d_x), 101);

    // Mid-line reset at x=300
    step(398);
    chk("d_pre_rst_x", 32'(d_x), 300);
    d_rst_n = 1'b0;
    step(1);
    chk("d_mrst_x", 32'(d_x), 799);
    chk("d_mrst_y", 32'(d_y), 524);
    chk("d_mrst_fcnt", 32'(d_frame_cnt), 0);
    chk("d_mrst_video", 32'(d_video_on), 0);
    chk("d_mrst_hsync", 32'(d_hsync), 1);
    chk("d_mrst_ls", 32'(d_line_start), 0);
    d_rst_n = 1'b1;
    step(1);
    chk("d_mrel_ptick", 32'(d_p_tick), 1);
    step(1);
    chk("d_mrel_x", 32'(d_x), 0);
    chk("d_mrel_y", 32'(d_y), 0);
    chk("d_mrel_fs", 32'(d_frame_start), 1);
    chk("d_mrel_fcnt", 32'(d_frame_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
